// File: rtl/l1_dcache_dm.sv
// l1_dcache_dm: direct-mapped, write-back, write-allocate L1 data cache.
// Define DCACHE_PERF_CNT_EN to build the hit/miss performance counters.
module l1_dcache_dm #(
    parameter int S_INDEX  = 3,
    parameter int S_OFFSET = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [3:0]   mem_byte_enable,
    input  logic [31:0]  mem_address,
    input  logic [31:0]  mem_wdata,
    output logic [31:0]  mem_rdata,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
);
    localparam int NSETS = 1 << S_INDEX;
    localparam int TAG_W = 32 - S_INDEX - S_OFFSET;
    localparam int WSEL  = S_OFFSET - 2;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        WB,
        FILL
    } state_t;

    state_t             r_state;
    logic [255:0]       r_data [NSETS];
    logic [TAG_W-1:0]   r_tag  [NSETS];
    logic [NSETS-1:0]   r_valid;
    logic [NSETS-1:0]   r_dirty;

    logic [TAG_W-1:0]   w_tag;
    logic [S_INDEX-1:0] w_idx;
    logic [WSEL-1:0]    w_word;
    logic [WSEL+4:0]    w_base;
    logic [255:0]       w_line;
    logic [255:0]       w_merged;
    logic [31:0]        w_old;
    logic [31:0]        w_new;
    logic               w_hit;
    logic               w_req;
    logic               w_unused;

    assign w_tag    = mem_address[31 -: TAG_W];
    assign w_idx    = mem_address[S_OFFSET +: S_INDEX];
    assign w_word   = mem_address[2 +: WSEL];
    assign w_base   = {w_word, 5'b0};
    assign w_unused = &{1'b0, mem_address[1:0]};
    assign w_line   = r_data[w_idx];
    assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_req    = mem_read | mem_write;

    assign w_old = w_line[w_base +: 32];
    assign w_new = {
        mem_byte_enable[3] ? mem_wdata[31:24] : w_old[31:24],
        mem_byte_enable[2] ? mem_wdata[23:16] : w_old[23:16],
        mem_byte_enable[1] ? mem_wdata[15:8]  : w_old[15:8],
        mem_byte_enable[0] ? mem_wdata[7:0]   : w_old[7:0]
    };

    always_comb begin
        w_merged = w_line;
        w_merged[w_base +: 32] = w_new;
    end

    assign mem_resp   = (r_state == CHECK) && w_hit;
    assign mem_rdata  = w_old;
    assign pmem_read  = (r_state == FILL);
    assign pmem_write = (r_state == WB);
    assign pmem_wdata = w_line;

    // Write-back targets the victim's tag; fills target the request's tag.
    assign pmem_address = (r_state == WB)
        ? {r_tag[w_idx], w_idx, {S_OFFSET{1'b0}}}
        : {w_tag, w_idx, {S_OFFSET{1'b0}}};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_req) r_state <= CHECK;
                end
                CHECK: begin
                    if (w_hit) begin
                        r_state <= IDLE;
                        if (mem_write) r_dirty[w_idx] <= 1'b1;
                    end else if (r_valid[w_idx] && r_dirty[w_idx]) begin
                        r_state <= WB;
                    end else begin
                        r_state <= FILL;
                    end
                end
                WB: begin
                    if (pmem_resp) r_state <= FILL;
                end
                FILL: begin
                    if (pmem_resp) begin
                        r_valid[w_idx] <= 1'b1;
                        r_dirty[w_idx] <= 1'b0;
                        r_state        <= CHECK;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && r_state == CHECK && w_hit && mem_write) begin
            r_data[w_idx] <= w_merged;
        end else if (!rst && r_state == FILL && pmem_resp) begin
            r_data[w_idx] <= pmem_rdata;
            r_tag[w_idx]  <= w_tag;
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;
    logic        r_refill;

    // The CHECK pass right after a fill completes the original miss.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
            r_refill   <= 1'b0;
        end else begin
            if (r_state == FILL && pmem_resp) r_refill <= 1'b1;
            if (r_state == CHECK) begin
                r_refill <= 1'b0;
                if (w_hit && !r_refill) r_hit_cnt <= r_hit_cnt + 32'd1;
                if (!w_hit) r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_l1_dcache_dm.sv
// tb_l1_dcache_dm: random and directed bench for l1_dcache_dm.
module tb_l1_dcache_dm;
    logic         clk = 1'b0;
    logic         rst;
    logic         mem_read;
    logic         mem_write;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_address;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;
    logic         mem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    int checks   = 0;
    int failures = 0;

`ifdef DCACHE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    always #5 clk = ~clk;

    l1_dcache_dm dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } ev_t;

    ev_t          ev_q[$];
    logic [255:0] bmem[int unsigned];
    int           lat_fixed = 0;
    int           lat_cnt;
    int           lat_tgt;
    bit           both_seen = 1'b0;

    // reference model: cache contents as seen by the core
    logic [23:0]  m_tag[8];
    bit           m_valid[8];
    bit           m_dirty[8];
    logic [255:0] m_data[8];
    int unsigned  m_hits;
    int unsigned  m_misses;

    function automatic logic [255:0] mem_line(input int unsigned la);
        logic [255:0] l;
        if (bmem.exists(la)) return bmem[la];
        for (int k = 0; k < 8; k++) begin
            if (la == 2) l[k*32 +: 32] = 32'hA000_0000 + 32'(k);
            else l[k*32 +: 32] = (la * 32'h9E37_79B1) ^ (32'(k) << 28) ^ 32'h5A5A_0000;
        end
        return l;
    endfunction

    // physical memory with variable latency
    initial begin
        int unsigned la;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        lat_cnt    = 0;
        lat_tgt    = 1;
        forever begin
            @(posedge clk);
            #1;
            if (pmem_read && pmem_write) both_seen = 1'b1;
            if (pmem_resp) begin
                pmem_resp = 1'b0;
                lat_cnt   = 0;
            end else if ((pmem_read || pmem_write) && !rst) begin
                lat_cnt++;
                if (lat_cnt >= lat_tgt) begin
                    la = pmem_address >> 5;
                    if (pmem_write) begin
                        bmem[la] = pmem_wdata;
                        ev_q.push_back('{1'b1, pmem_address, pmem_wdata});
                    end else begin
                        pmem_rdata = mem_line(la);
                        ev_q.push_back('{1'b0, pmem_address, pmem_rdata});
                    end
                    pmem_resp = 1'b1;
                    lat_cnt   = 0;
                    lat_tgt   = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 4));
                end
            end else begin
                lat_cnt = 0;
            end
        end
    end

    task automatic model_reset();
        for (int s = 0; s < 8; s++) begin
            m_valid[s] = 1'b0;
            m_dirty[s] = 1'b0;
        end
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic model_req(
        input bit wr, input logic [31:0] a, input logic [3:0] be,
        input logic [31:0] wd, output logic [31:0] exp_rd, output bit hit,
        output bit exp_wb, output logic [31:0] wb_addr,
        output logic [255:0] wb_data, output logic [31:0] fill_addr);
        int s = int'(a[7:5]);
        int w = int'(a[4:2]);
        logic [31:0] word;
        hit       = m_valid[s] && (m_tag[s] == a[31:8]);
        exp_wb    = !hit && m_valid[s] && m_dirty[s];
        wb_addr   = {m_tag[s], a[7:5], 5'b0};
        wb_data   = m_data[s];
        fill_addr = {a[31:5], 5'b0};
        if (hit) begin
            m_hits++;
        end else begin
            m_misses++;
            m_data[s]  = mem_line(a >> 5);
            m_tag[s]   = a[31:8];
            m_valid[s] = 1'b1;
            m_dirty[s] = 1'b0;
        end
        word = m_data[s][w*32 +: 32];
        if (wr) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) word[8*b +: 8] = wd[8*b +: 8];
            m_data[s][w*32 +: 32] = word;
            m_dirty[s] = 1'b1;
        end
        exp_rd = word;
    endtask

    // issue one core request; called at posedge+1, returns at posedge+1
    task automatic do_req(
        input bit wr, input bit rd_also, input logic [31:0] a,
        input logic [3:0] be, input logic [31:0] wd,
        output logic [31:0] rd, output int cyc, output bit to);
        ev_q.delete();
        mem_address     = a;
        mem_write       = wr;
        mem_read        = !wr || rd_also;
        mem_byte_enable = be;
        mem_wdata       = wd;
        rd  = '0;
        cyc = 0;
        to  = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (mem_resp) begin
                rd = mem_rdata;
                to = 1'b0;
                break;
            end
        end
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_read = 1'b0;
        mem_write = 1'b0;
        mem_address = '0;
        mem_byte_enable = '0;
        mem_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        checks++;
        if (mem_resp !== 1'b0) begin
            failures++; $display("FAIL reset_mem_resp: got %b expected 0", mem_resp);
        end
        checks++;
        if ({pmem_read, pmem_write} !== 2'b00) begin
            failures++; $display("FAIL reset_pmem: got %b%b expected 00", pmem_read, pmem_write);
        end
        checks++;
        if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            failures++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", hit_count, miss_count);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic [31:0] rd, er, wa, fa;
        logic [255:0] wdat, l;
        bit hit, ewb, to;
        int cyc;

        model_req(0, 32'h40, 4'h0, 32'h0, er, hit, ewb, wa, wdat, fa);
        do_req(0, 0, 32'h40, 4'h0, 32'h0, rd, cyc, to);
        checks++;
        if (to || rd !== 32'hA000_0000) begin
            failures++; $display("FAIL cold_read: got %h to=%b expected a0000000", rd, to);
        end
        checks++;
        if (ev_q.size() != 1 || ev_q[0].wr || ev_q[0].addr !== 32'h40) begin
            failures++; $display("FAIL cold_fill: got %0d events expected one fill at 00000040", ev_q.size());
        end

        model_req(0, 32'h48, 4'h0, 32'h0, er, hit, ewb, wa, wdat, fa);
        do_req(0, 0, 32'h48, 4'h0, 32'h0, rd, cyc, to);
        checks++;
        if (to || rd !== 32'hA000_0002 || cyc != 1 || ev_q.size() != 0) begin
            failures++;
            $display("FAIL read_hit: got %h cyc=%0d ev=%0d expected a0000002 cyc=1 ev=0", rd, cyc, ev_q.size());
        end

        model_req(1, 32'h44, 4'b0011, 32'hDEAD_BEEF, er, hit, ewb, wa, wdat, fa);
        do_req(1, 0, 32'h44, 4'b0011, 32'hDEAD_BEEF, rd, cyc, to);
        checks++;
        if (to || cyc != 1 || ev_q.size() != 0) begin
            failures++; $display("FAIL write_hit: got cyc=%0d ev=%0d expected cyc=1 ev=0", cyc, ev_q.size());
        end

        model_req(0, 32'h44, 4'h0, 32'h0, er, hit, ewb, wa, wdat, fa);
        do_req(0, 0, 32'h44, 4'h0, 32'h0, rd, cyc, to);
        checks++;
        if (to || rd !== 32'hA000_BEEF) begin
            failures++; $display("FAIL write_merge: got %h expected a000beef", rd);
        end

        model_req(0, 32'h1044, 4'h0, 32'h0, er, hit, ewb, wa, wdat, fa);
        do_req(0, 0, 32'h1044, 4'h0, 32'h0, rd, cyc, to);
        checks++;
        if (ev_q.size() != 2 || !ev_q[0].wr || ev_q[0].addr !== 32'h40
            || ev_q[0].data[63:32] !== 32'hA000_BEEF) begin
            failures++; $display("FAIL evict_wb: got %0d events expected wb at 00000040 with a000beef", ev_q.size());
        end
        checks++;
        if (ev_q.size() != 2 || ev_q[1].wr || ev_q[1].addr !== 32'h1040) begin
            failures++; $display("FAIL evict_fill: got %0d events expected fill at 00001040 second", ev_q.size());
        end
        l = mem_line(32'h1040 >> 5);
        checks++;
        if (to || rd !== l[63:32]) begin
            failures++; $display("FAIL evict_read: got %h expected %h", rd, l[63:32]);
        end

        checks++;
        if (hit_count !== (PERF ? 32'd3 : 32'd0) || miss_count !== (PERF ? 32'd2 : 32'd0)) begin
            failures++; $display("FAIL plan_counters: got %0d/%0d expected %0d/%0d",
                hit_count, miss_count, PERF ? 3 : 0, PERF ? 2 : 0);
        end
    endtask

    task automatic test_spurious_resp();
        logic [31:0] rd, er, wa, fa;
        logic [255:0] wdat;
        bit hit, ewb, to;
        int cyc;
        #1;
        pmem_rdata = {8{$urandom()}};
        pmem_resp  = 1'b1;
        @(posedge clk);
        #1;
        model_req(0, 32'h1044, 4'h0, 32'h0, er, hit, ewb, wa, wdat, fa);
        do_req(0, 0, 32'h1044, 4'h0, 32'h0, rd, cyc, to);
        checks++;
        if (to || rd !== er || cyc != 1 || ev_q.size() != 0) begin
            failures++; $display("FAIL spurious_resp: got %h cyc=%0d expected %h cyc=1", rd, cyc, er);
        end
    endtask

    task automatic test_rst_mid_fill();
        logic [31:0] rd, er, wa, fa;
        logic [255:0] wdat;
        bit hit, ewb, to, seen;
        int cyc;
        lat_fixed = 20;
        lat_tgt   = 20;
        ev_q.delete();
        mem_address = 32'h2040;
        mem_read    = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (pmem_read) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen || pmem_address !== 32'h2040) begin
            failures++; $display("FAIL rst_fill_start: got seen=%b addr=%h expected 1 00002040", seen, pmem_address);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_read = 1'b0;
        model_reset();
        lat_fixed = 0;
        checks++;
        if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
            failures++; $display("FAIL rst_abort: got %b%b expected 00", pmem_read, pmem_write);
        end
        model_req(0, 32'h1040, 4'h0, 32'h0, er, hit, ewb, wa, wdat, fa);
        do_req(0, 0, 32'h1040, 4'h0, 32'h0, rd, cyc, to);
        checks++;
        if (to || ev_q.size() != 1 || ev_q[0].wr || ev_q[0].addr !== 32'h1040 || rd !== er) begin
            failures++; $display("FAIL rst_refill: got %h ev=%0d expected %h with one fill", rd, ev_q.size(), er);
        end
        checks++;
        if (hit_count !== 32'd0 || miss_count !== (PERF ? 32'd1 : 32'd0)) begin
            failures++; $display("FAIL rst_counters: got %0d/%0d expected 0/%0d", hit_count, miss_count, PERF ? 1 : 0);
        end
    endtask

    task automatic test_random();
        logic [31:0] tags[4];
        logic [31:0] rd, er, wa, fa, a, wd;
        logic [255:0] wdat;
        logic [3:0] be;
        bit hit, ewb, to, wr, both;
        int cyc, n;
        tags[0] = 32'h0;
        tags[1] = 32'h1;
        tags[2] = 32'h10;
        tags[3] = 32'hABCDE;
        for (int i = 0; i < 200; i++) begin
            a = (tags[$urandom_range(0, 3)] << 8) | 32'($urandom_range(0, 255));
            wr = ($urandom_range(0, 1) == 1);
            both = ($urandom_range(0, 9) == 0);
            be = 4'($urandom());
            wd = $urandom();
            model_req(wr, a, be, wd, er, hit, ewb, wa, wdat, fa);
            do_req(wr, both, a, be, wd, rd, cyc, to);
            checks++;
            if (to || (!wr && rd !== er)) begin
                failures++; $display("FAIL rand_data[%0d]: addr %h got %h to=%b expected %h", i, a, rd, to, er);
            end
            checks++;
            if (hit ? (cyc != 1) : (cyc < 3)) begin
                failures++; $display("FAIL rand_latency[%0d]: got %0d cycles hit=%b", i, cyc, hit);
            end
            n = hit ? 0 : (ewb ? 2 : 1);
            checks++;
            if (ev_q.size() != n) begin
                failures++; $display("FAIL rand_pmem_count[%0d]: got %0d expected %0d", i, ev_q.size(), n);
            end else if (n != 0) begin
                checks++;
                if (ev_q[n-1].wr || ev_q[n-1].addr !== fa) begin
                    failures++; $display("FAIL rand_fill[%0d]: got %h expected %h", i, ev_q[n-1].addr, fa);
                end
                if (ewb) begin
                    checks++;
                    if (!ev_q[0].wr || ev_q[0].addr !== wa || ev_q[0].data !== wdat) begin
                        failures++; $display("FAIL rand_wb[%0d]: got %h expected %h", i, ev_q[0].addr, wa);
                    end
                end
            end
        end
        checks++;
        if (both_seen) begin
            failures++; $display("FAIL pmem_exclusive: got both asserted expected never");
        end
        checks++;
        if (hit_count !== (PERF ? m_hits : 0) || miss_count !== (PERF ? m_misses : 0)) begin
            failures++; $display("FAIL rand_counters: got %0d/%0d expected %0d/%0d",
                hit_count, miss_count, PERF ? m_hits : 0, PERF ? m_misses : 0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_spurious_resp();
        test_rst_mid_fill();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
